// File: rtl/ctrlsoc_busmux.sv
// Address decoder/interconnect between the picorv32 native memory port and NSLAVES slave ports,
// with write protection, wait-state tolerant slaves, a timeout watchdog and a sticky bus error.
module ctrlsoc_busmux #(
  parameter int unsigned               NSLAVES     = 4,
  parameter logic [32*NSLAVES-1:0]     REGION_BASE = {32'h01000000, 32'h00100000, 32'h00010000, 32'h00000000},
  parameter logic [32*NSLAVES-1:0]     REGION_MASK = {32'hFFFFFFFF, 32'hFF000000, 32'hFFFF0000, 32'hFFFF0000},
  parameter logic [NSLAVES-1:0]        RO_MASK     = 4'b0100,
  parameter int unsigned               TIMEOUT     = 255,
  parameter bit                        ERR_ACK     = 1'b0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    mem_valid,
  input  logic                    mem_instr,
  output logic                    mem_ready,
  input  logic [31:0]             mem_addr,
  input  logic [31:0]             mem_wdata,
  input  logic [3:0]              mem_wstrb,
  output logic [31:0]             mem_rdata,
  output logic [NSLAVES-1:0]      s_valid,
  output logic [31:0]             s_addr,
  output logic [31:0]             s_wdata,
  output logic [3:0]              s_wstrb,
  input  logic [NSLAVES-1:0]      s_ready,
  input  logic [32*NSLAVES-1:0]   s_rdata,
  input  logic                    err_clear,
  output logic                    buserror,
  output logic [31:0]             err_addr
);

  localparam int unsigned CW = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_MAX  = '1;
  localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
  localparam logic [31:0]   ERR_DATA = 32'hBADBADBA;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_BUSY  = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;
  localparam logic [1:0] ST_ERROR = 2'd3;

  logic [1:0]         state_q, state_d;
  logic [NSLAVES-1:0] s_valid_q, s_valid_d;
  logic [31:0]        s_addr_q, s_addr_d, s_wdata_q, s_wdata_d;
  logic [3:0]         s_wstrb_q, s_wstrb_d;
  logic [31:0]        mem_rdata_q, mem_rdata_d;
  logic               mem_ready_q, mem_ready_d;
  logic               buserror_q, buserror_d;
  logic [31:0]        err_addr_q, err_addr_d;
  logic [CW-1:0]      cnt_q, cnt_d;

  logic [NSLAVES-1:0] sel_c;
  logic               found_c, dec_err_c, rdy_c, err_set_c;
  logic [31:0]        rdata_c;
  logic               unused_instr;

  assign unused_instr = mem_instr;

  // Priority decode: the lowest-index matching region wins.
  always_comb begin
    sel_c   = '0;
    found_c = 1'b0;
    for (int i = 0; i < int'(NSLAVES); i++) begin
      if (!found_c && ((mem_addr & REGION_MASK[32*i +: 32]) == REGION_BASE[32*i +: 32])) begin
        sel_c[i] = 1'b1;
        found_c  = 1'b1;
      end
    end
    dec_err_c = !found_c || ((|mem_wstrb) && (|(sel_c & RO_MASK)));
  end

  always_comb begin
    rdy_c   = |(s_ready & s_valid_q);
    rdata_c = '0;
    for (int i = 0; i < int'(NSLAVES); i++) begin
      if (s_valid_q[i]) rdata_c = s_rdata[32*i +: 32];
    end
  end

  always_comb begin
    state_d     = state_q;
    s_valid_d   = s_valid_q;
    s_addr_d    = s_addr_q;
    s_wdata_d   = s_wdata_q;
    s_wstrb_d   = s_wstrb_q;
    mem_rdata_d = mem_rdata_q;
    mem_ready_d = 1'b0;
    cnt_d       = cnt_q;
    err_set_c   = 1'b0;
    case (state_q)
      // mem_ready_q high means the CPU has not yet dropped the completed request.
      ST_IDLE: begin
        if (mem_valid && !buserror_q && !mem_ready_q) begin
          if (dec_err_c) begin
            err_set_c = 1'b1;
          end else begin
            s_addr_d  = mem_addr;
            s_wdata_d = mem_wdata;
            s_wstrb_d = mem_wstrb;
            s_valid_d = sel_c;
            cnt_d     = '0;
            state_d   = ST_BUSY;
          end
        end
      end
      ST_BUSY: begin
        if (rdy_c) begin
          s_valid_d   = '0;
          mem_rdata_d = rdata_c;
          state_d     = ST_DONE;
        end else if ((TIMEOUT != 0) && (cnt_q == CNT_LAST)) begin
          s_valid_d = '0;
          err_set_c = 1'b1;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_DONE: begin
        mem_ready_d = 1'b1;
        state_d     = ST_IDLE;
      end
      ST_ERROR: begin
        if (ERR_ACK)        state_d = ST_DONE;
        else if (err_clear) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (err_set_c) begin
      state_d = ST_ERROR;
      if (ERR_ACK) mem_rdata_d = ERR_DATA;
    end
    // A new fault outranks a simultaneous clear; only the first fault address is kept.
    buserror_d = err_set_c ? 1'b1 : (err_clear ? 1'b0 : buserror_q);
    err_addr_d = (err_set_c && !buserror_q) ? mem_addr : err_addr_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      s_valid_q   <= '0;
      s_addr_q    <= '0;
      s_wdata_q   <= '0;
      s_wstrb_q   <= '0;
      mem_rdata_q <= '0;
      mem_ready_q <= 1'b0;
      buserror_q  <= 1'b0;
      err_addr_q  <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      s_valid_q   <= s_valid_d;
      s_addr_q    <= s_addr_d;
      s_wdata_q   <= s_wdata_d;
      s_wstrb_q   <= s_wstrb_d;
      mem_rdata_q <= mem_rdata_d;
      mem_ready_q <= mem_ready_d;
      buserror_q  <= buserror_d;
      err_addr_q  <= err_addr_d;
      cnt_q       <= cnt_d;
    end
  end

  assign mem_ready = mem_ready_q;
  assign mem_rdata = mem_rdata_q;
  assign s_valid   = s_valid_q;
  assign s_addr    = s_addr_q;
  assign s_wdata   = s_wdata_q;
  assign s_wstrb   = s_wstrb_q;
  assign buserror  = buserror_q;
  assign err_addr  = err_addr_q;

endmodule
